// File: rtl/demux4_capture.sv
// Registered 1-to-4 demultiplexer: steers a WIDTH-bit stream into four output registers,
// either by explicit select (immediate write) or by an auto slot pointer with whole-frame commit.
module demux4_capture #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [1:0]       sel,
    input  logic             auto_mode,
    input  logic             clear,
    output logic [WIDTH-1:0] Dout3,
    output logic [WIDTH-1:0] Dout2,
    output logic [WIDTH-1:0] Dout1,
    output logic [WIDTH-1:0] Dout0,
    output logic [1:0]       slot,
    output logic             frame_done
);

    logic [WIDTH-1:0] shadow_q [4];
    logic [WIDTH-1:0] shadow_d [4];
    logic [WIDTH-1:0] dout_q   [4];
    logic [WIDTH-1:0] dout_d   [4];
    logic [1:0]       slot_q, slot_d;
    logic             frame_done_q, frame_done_d;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            shadow_d[i] = shadow_q[i];
            dout_d[i]   = dout_q[i];
        end
        slot_d       = slot_q;
        frame_done_d = 1'b0;

        if (clear) begin
            // Abort drops any coincident beat; committed outputs are left untouched.
            slot_d = '0;
            for (int unsigned i = 0; i < 4; i++) begin
                shadow_d[i] = '0;
            end
        end else if (!auto_mode) begin
            slot_d = '0;
            if (din_valid) begin
                shadow_d[sel] = din;
                dout_d[sel]   = din;
            end
        end else if (din_valid) begin
            shadow_d[slot_q] = din;
            slot_d           = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
                // Last beat bypasses its shadow so the whole frame lands on one edge.
                for (int unsigned i = 0; i < 3; i++) begin
                    dout_d[i] = shadow_q[i];
                end
                dout_d[3]    = din;
                frame_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                dout_q[i]   <= '0;
            end
            slot_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                shadow_q[i] <= shadow_d[i];
                dout_q[i]   <= dout_d[i];
            end
            slot_q       <= slot_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign Dout3      = dout_q[3];
    assign Dout2      = dout_q[2];
    assign Dout1      = dout_q[1];
    assign Dout0      = dout_q[0];
    assign slot       = slot_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/demux4_capture.md
Name: demux4_capture

Overview:
Registered 1-to-4 demultiplexer for 4-bit values. It is the write-side counterpart of the 4-input, 4-bit select mux used for digit data. A single WIDTH-bit input stream is steered into one of four output registers (Dout3..Dout0), either by an explicit 2-bit select or by an internal auto-incrementing slot pointer. In auto mode the four outputs update together once a full 4-value frame has been captured. The block feeds the digit mux or display path with stable, glitch-free values.

Parameters:
WIDTH, 4, bit width of the input value and of each output register.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
din  input  WIDTH  value to capture.
din_valid  input  1  capture strobe; din is written on any clk edge where this is high.
sel  input  2  destination slot in manual mode (0→Dout0 … 3→Dout3); ignored in auto mode.
auto_mode  input  1  1 = auto-increment pointer with frame commit; 0 = manual select, immediate write.
clear  input  1  synchronous abort of a partial frame.
Dout3  output  WIDTH  slot 3 register.
Dout2  output  WIDTH  slot 2 register.
Dout1  output  WIDTH  slot 1 register.
Dout0  output  WIDTH  slot 0 register.
slot  output  2  current auto-mode write pointer.
frame_done  output  1  one-cycle pulse when a frame is committed.

Behaviour:
- Reset (sync, highest priority):
  - Dout3..Dout0 = 0, shadow registers = 0.
  - slot = 0, frame_done = 0.
- Priority on each clk edge: reset > clear > din_valid.
- Manual mode (auto_mode = 0):
  - On din_valid, write din into Dout[sel] and shadow[sel]. The new value is visible on the cycle after the edge (1-cycle latency).
  - Other slots hold their values.
  - slot is forced to 0 every cycle.
  - frame_done stays 0.
- Auto mode (auto_mode = 1):
  - On din_valid, write din into shadow[slot], then slot = slot + 1 modulo 4.
  - On the beat written at slot = 3:
    - the same edge copies all four shadows to Dout3..Dout0, with the slot-3 value taken from din directly;
    - slot wraps to 0;
    - frame_done = 1 for exactly the following cycle.
  - Outputs never show a partially captured frame.
- Back-to-back din_valid is supported at full rate, one value per cycle.
  - Consecutive frames produce frame_done pulses exactly 4 cycles apart.
- clear:
  - slot = 0 and shadows = 0.
  - Dout3..Dout0 hold their values.
  - frame_done = 0.
  - A din_valid coincident with clear is dropped.
- auto_mode 1→0 mid-frame: the partial frame is discarded (slot forced to 0; shadows keep stale data and are overwritten by the next frame). Dout3..Dout0 hold.
- auto_mode 0→1: capture starts at slot 0.
- Reset asserted mid-frame: full reset as above; no frame_done.
- frame_done is registered, never combinational, and is deasserted on every cycle without a commit.

Test Plan:
- Reset: hold reset 2 cycles with din_valid = 1, din = 4'hF → all Dout = 0, slot = 0, frame_done = 0.
- Manual mode: write 4'hA to sel = 2, then 4'h5 to sel = 0 → Dout2 = A one cycle after the first write, Dout0 = 5 one cycle after the second, Dout3 = Dout1 = 0, frame_done never high.
- Auto frame, back-to-back: din = 1, 2, 3, 4 on consecutive cycles → Dout0..Dout3 stay 0 during the first 3 beats, then Dout0 = 1, Dout1 = 2, Dout2 = 3, Dout3 = 4 simultaneously; frame_done single pulse; slot reads 1, 2, 3, 0.
- Gapped auto frames: values 7, 8, 9, A, B, C, D, E with idle cycles between beats → two commits, final Dout3..Dout0 = E, D, C, B; exactly two frame_done pulses.
- Clear mid-frame: after committed frame {4, 3, 2, 1}, send 9, 9, then clear together with din_valid = 1, din = 6 → Dout unchanged at {4, 3, 2, 1}, slot = 0, value 6 dropped; next 4 beats commit normally.
- Mode switch/reset mid-frame: 2 auto beats, drop auto_mode for 1 cycle, re-assert, send 4 beats (5, 6, 7, 8) → commit {8, 7, 6, 5}. Repeat with reset after 3 beats → all outputs 0 and no frame_done.
